// File: rtl/mailbox_port_arbiter_pkg.sv
// Shared types and defaults for the mailbox port arbiter.
// The optional WAIT timeout is enabled by defining MAILBOX_ARB_TIMEOUT_EN.
package mailbox_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int unsigned NUM_REQ_DEF = 4;
    localparam int unsigned ADDR_W_DEF  = 6;
    localparam int unsigned DATA_W_DEF  = 32;
    localparam int unsigned TIMEOUT_DEF = 256;

    // Index width that never collapses to zero bits.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mailbox_port_arbiter_if.sv
// Requester-side and mailbox-side signals of the mailbox port arbiter.
// The slave modport is the arbiter's view, the master modport is the environment's.
interface mailbox_port_arbiter_if #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ADDR_W  = 6,
    parameter int unsigned DATA_W  = 32
);
    logic [NUM_REQ-1:0]        req_write;
    logic [NUM_REQ-1:0]        req_read;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_wdata;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ-1:0]        req_err;
    logic [DATA_W-1:0]         req_rdata;
    logic                      mbx_write;
    logic                      mbx_read;
    logic [ADDR_W-1:0]         mbx_addr;
    logic [DATA_W-1:0]         mbx_wdata;
    logic                      mbx_ready;
    logic [DATA_W-1:0]         mbx_rdata;

    modport slave (
        input  req_write, req_read, req_addr, req_wdata, mbx_ready, mbx_rdata,
        output req_ready, req_err, req_rdata, mbx_write, mbx_read, mbx_addr, mbx_wdata
    );

    modport master (
        output req_write, req_read, req_addr, req_wdata, mbx_ready, mbx_rdata,
        input  req_ready, req_err, req_rdata, mbx_write, mbx_read, mbx_addr, mbx_wdata
    );
endinterface

// File: rtl/mailbox_port_arbiter_rr_pick.sv
// Combinational round-robin selector: first set request after i_last, with wrap-around.
module mailbox_rr_pick #(
    parameter int unsigned N  = 4,
    parameter int unsigned IW = 2
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_last,
    output logic [IW-1:0] o_grant_c,
    output logic          o_any_c
);

    int   w_idx;
    logic w_found;

    always_comb begin
        o_grant_c = '0;
        o_any_c   = |i_req;
        w_found   = 1'b0;
        w_idx     = 0;
        for (int k = 1; k <= int'(N); k++) begin
            w_idx = (int'(i_last) + k) % int'(N);
            if (!w_found && i_req[IW'(w_idx)]) begin
                o_grant_c = IW'(w_idx);
                w_found   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mailbox_port_arbiter.sv
// Round-robin arbiter sharing one mailbox register port among NUM_REQ requesters.
// Define MAILBOX_ARB_TIMEOUT_EN to abort WAIT after TIMEOUT_CYCLES without mbx_ready.
module mailbox_port_arbiter
    import mailbox_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ        = NUM_REQ_DEF,
    parameter int unsigned ADDR_W         = ADDR_W_DEF,
    parameter int unsigned DATA_W         = DATA_W_DEF,
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    mailbox_port_arbiter_if.slave bus
);

    localparam int unsigned IDX_W = idx_w(NUM_REQ);

    state_t              r_state, w_state;
    logic [IDX_W-1:0]    r_grant, w_grant;
    logic [IDX_W-1:0]    r_last, w_last;
    logic [IDX_W-1:0]    w_pick;
    logic                w_any;
    logic [NUM_REQ-1:0]  w_req;
    logic [ADDR_W-1:0]   r_addr, w_addr, w_sel_addr;
    logic [DATA_W-1:0]   r_wdata, w_wdata, w_sel_wdata;
    logic                w_sel_wr;
    logic                r_mbx_write, w_mbx_write;
    logic                r_mbx_read, w_mbx_read;
    logic [NUM_REQ-1:0]  r_req_ready, w_req_ready;
    logic [DATA_W-1:0]   r_rdata, w_rdata;
`ifdef MAILBOX_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = idx_w(TIMEOUT_CYCLES);
    logic [CNT_W-1:0]    r_cnt, w_cnt;
    logic [NUM_REQ-1:0]  r_req_err, w_req_err;
`endif

    assign w_req = bus.req_write | bus.req_read;

    mailbox_rr_pick #(
        .N  (NUM_REQ),
        .IW (IDX_W)
    ) u_pick (
        .i_req     (w_req),
        .i_last    (r_last),
        .o_grant_c (w_pick),
        .o_any_c   (w_any)
    );

    // Mux the winning requester's payload; write wins when both strobes are set.
    always_comb begin
        w_sel_addr  = '0;
        w_sel_wdata = '0;
        w_sel_wr    = 1'b0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (IDX_W'(k) == w_pick) begin
                w_sel_addr  = bus.req_addr[k*ADDR_W +: ADDR_W];
                w_sel_wdata = bus.req_wdata[k*DATA_W +: DATA_W];
                w_sel_wr    = bus.req_write[k];
            end
        end
    end

    always_comb begin
        w_state     = r_state;
        w_grant     = r_grant;
        w_last      = r_last;
        w_addr      = r_addr;
        w_wdata     = r_wdata;
        w_mbx_write = r_mbx_write;
        w_mbx_read  = r_mbx_read;
        w_req_ready = '0;
        w_rdata     = r_rdata;
`ifdef MAILBOX_ARB_TIMEOUT_EN
        w_cnt       = r_cnt;
        w_req_err   = '0;
`endif
        unique case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_grant     = w_pick;
                    w_last      = w_pick;
                    w_addr      = w_sel_addr;
                    w_wdata     = w_sel_wdata;
                    w_mbx_write = w_sel_wr;
                    w_mbx_read  = ~w_sel_wr;
                    w_state     = WAIT;
`ifdef MAILBOX_ARB_TIMEOUT_EN
                    w_cnt       = '0;
`endif
                end
            end
            WAIT: begin
                if (bus.mbx_ready) begin
                    w_rdata              = r_mbx_read ? bus.mbx_rdata : '0;
                    w_req_ready[r_grant] = 1'b1;
                    w_mbx_write          = 1'b0;
                    w_mbx_read           = 1'b0;
                    w_state              = DONE;
                end
`ifdef MAILBOX_ARB_TIMEOUT_EN
                else if (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    w_rdata              = '0;
                    w_req_ready[r_grant] = 1'b1;
                    w_req_err[r_grant]   = 1'b1;
                    w_mbx_write          = 1'b0;
                    w_mbx_read           = 1'b0;
                    w_state              = DONE;
                end else begin
                    w_cnt = r_cnt + CNT_W'(1);
                end
`endif
            end
            DONE: begin
                // Strobe-low gap cycle; req_ready drops via its default.
                w_state = IDLE;
            end
            default: begin
                w_state     = IDLE;
                w_mbx_write = 1'b0;
                w_mbx_read  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_grant     <= '0;
            r_last      <= IDX_W'(NUM_REQ - 1);
            r_addr      <= '0;
            r_wdata     <= '0;
            r_mbx_write <= 1'b0;
            r_mbx_read  <= 1'b0;
            r_req_ready <= '0;
            r_rdata     <= '0;
        end else begin
            r_state     <= w_state;
            r_grant     <= w_grant;
            r_last      <= w_last;
            r_addr      <= w_addr;
            r_wdata     <= w_wdata;
            r_mbx_write <= w_mbx_write;
            r_mbx_read  <= w_mbx_read;
            r_req_ready <= w_req_ready;
            r_rdata     <= w_rdata;
        end
    end

`ifdef MAILBOX_ARB_TIMEOUT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt     <= '0;
            r_req_err <= '0;
        end else begin
            r_cnt     <= w_cnt;
            r_req_err <= w_req_err;
        end
    end

    assign bus.req_err = r_req_err;
`else
    assign bus.req_err = '0;
`endif

    assign bus.req_ready = r_req_ready;
    assign bus.req_rdata = r_rdata;
    assign bus.mbx_write = r_mbx_write;
    assign bus.mbx_read  = r_mbx_read;
    assign bus.mbx_addr  = r_addr;
    assign bus.mbx_wdata = r_wdata;

endmodule

// File: tb/tb_mailbox_port_arbiter.sv
// Scoreboard bench for mailbox_port_arbiter with a behavioural mailbox model.
// The timeout scenario runs only when MAILBOX_ARB_TIMEOUT_EN is defined.
module tb_mailbox_port_arbiter;

    localparam int unsigned NR = 4;
    localparam int unsigned AW = 6;
    localparam int unsigned DW = 32;

    typedef struct {
        int          idx;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic clk;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb_q[$];
    exp_t sb_e;

    logic        mdl_stall;
    logic [31:0] mdl_rdata;

    mailbox_port_arbiter_if #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW)) bus ();

    mailbox_port_arbiter #(
        .NUM_REQ        (NR),
        .ADDR_W         (AW),
        .DATA_W         (DW),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Mailbox model: registered one-cycle ready pulse one cycle after a strobe.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.mbx_ready <= 1'b0;
            bus.mbx_rdata <= '0;
        end else if ((bus.mbx_write || bus.mbx_read) && !bus.mbx_ready && !mdl_stall) begin
            bus.mbx_ready <= 1'b1;
            bus.mbx_rdata <= bus.mbx_read ? mdl_rdata : 32'hDEAD_BEEF;
        end else begin
            bus.mbx_ready <= 1'b0;
        end
    end

    // Completion monitor: every req_ready pulse must match the scoreboard head.
    always @(negedge clk) begin
        if (!reset && bus.req_ready != '0) begin
            if (sb_q.size() == 0) begin
                chk("sb_unexpected", 64'(bus.req_ready), 64'd0);
            end else begin
                sb_e = sb_q.pop_front();
                chk("sb_grant", 64'(bus.req_ready), 64'(NR'(1) << sb_e.idx));
                chk("sb_rdata", 64'(bus.req_rdata), 64'(sb_e.rdata));
                chk("sb_err", 64'(bus.req_err), sb_e.err ? 64'(NR'(1) << sb_e.idx) : 64'd0);
            end
        end
    end

    task automatic issue(input int i, input bit wr, input bit rd,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.req_write[i] = wr;
        bus.req_read[i]  = rd;
        bus.req_addr[i*AW +: AW]  = a;
        bus.req_wdata[i*DW +: DW] = d;
    endtask

    task automatic push(input int i, input logic [31:0] rd, input logic err);
        exp_t e;
        e.idx = i; e.rdata = rd; e.err = err;
        sb_q.push_back(e);
    endtask

    // Waits for requester i's req_ready, then drops its strobes during DONE.
    task automatic wait_done(input int i, input int budget, output int cyc,
                             output int nwr, output int nrd,
                             output logic [AW-1:0] a0, output logic [DW-1:0] d0);
        bit seen;
        seen = 1'b0; cyc = 0; nwr = 0; nrd = 0; a0 = '0; d0 = '0;
        while (!seen && cyc < budget) begin
            @(negedge clk);
            cyc++;
            if (bus.req_ready[i]) begin
                seen = 1'b1;
            end else begin
                if (nwr + nrd == 0 && (bus.mbx_write || bus.mbx_read)) begin
                    a0 = bus.mbx_addr;
                    d0 = bus.mbx_wdata;
                end
                nwr += int'(bus.mbx_write);
                nrd += int'(bus.mbx_read);
            end
        end
        if (!seen) chk("wait_ready_timeout", 64'd0, 64'd1);
        bus.req_write[i] = 1'b0;
        bus.req_read[i]  = 1'b0;
    endtask

    initial begin
        int cyc, nwr, nrd, comp, rises, last_rise, seen_rdy;
        logic s, prev;
        logic [AW-1:0] a0;
        logic [DW-1:0] d0;

        reset = 1'b1;
        mdl_stall = 1'b0;
        mdl_rdata = '0;
        bus.req_write = '0;
        bus.req_read  = '0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;

        // Reset state with requesters 0, 1, 3 already requesting.
        issue(0, 1, 0, 6'h01, 32'h1000_0000);
        issue(1, 1, 0, 6'h02, 32'h1000_0001);
        issue(3, 1, 0, 6'h03, 32'h1000_0003);
        repeat (2) @(negedge clk);
        chk("rst_strobes", {62'd0, bus.mbx_write, bus.mbx_read}, 64'd0);
        chk("rst_ready", 64'(bus.req_ready), 64'd0);
        chk("rst_err", 64'(bus.req_err), 64'd0);
        chk("rst_rdata", 64'(bus.req_rdata), 64'd0);
        chk("rst_addr", 64'(bus.mbx_addr), 64'd0);

        // Contention: round-robin order and 4-cycle grant period.
        for (int k = 0; k < 2; k++) begin
            push(0, 32'd0, 1'b0); push(1, 32'd0, 1'b0); push(3, 32'd0, 1'b0);
        end
        reset = 1'b0;
        comp = 0; rises = 0; last_rise = 0; prev = 1'b0;
        for (int c = 1; c <= 80 && comp < 6; c++) begin
            @(negedge clk);
            s = bus.mbx_write | bus.mbx_read;
            if (s && !prev) begin
                if (rises > 0) chk("rr_period", 64'(c - last_rise), 64'd4);
                last_rise = c;
                rises++;
            end
            prev = s;
            if (bus.req_ready != '0) comp++;
        end
        chk("rr_completions", 64'(comp), 64'd6);
        bus.req_write = '0;
        repeat (2) @(negedge clk);

        // Single write on requester 0.
        issue(0, 1, 0, 6'h30, 32'hA5A5_0001);
        push(0, 32'd0, 1'b0);
        wait_done(0, 20, cyc, nwr, nrd, a0, d0);
        chk("wr_latency", 64'(cyc), 64'd3);
        chk("wr_strobe_cycles", 64'(nwr), 64'd2);
        chk("wr_no_read", 64'(nrd), 64'd0);
        chk("wr_addr", 64'(a0), 64'h30);
        chk("wr_wdata", 64'(d0), 64'hA5A5_0001);
        repeat (2) @(negedge clk);

        // Single read on requester 2.
        mdl_rdata = 32'h1234_5678;
        issue(2, 0, 1, 6'h20, 32'h0);
        push(2, 32'h1234_5678, 1'b0);
        wait_done(2, 20, cyc, nwr, nrd, a0, d0);
        chk("rd_done_strobes", {62'd0, bus.mbx_write, bus.mbx_read}, 64'd0);
        chk("rd_strobe_cycles", 64'(nrd), 64'd2);
        chk("rd_addr", 64'(a0), 64'h20);
        @(negedge clk);
        chk("rd_ready_drop", 64'(bus.req_ready), 64'd0);
        chk("rd_rdata_hold", 64'(bus.req_rdata), 64'h1234_5678);
        @(negedge clk);

        // Simultaneous write+read on requester 1: write only.
        issue(1, 1, 1, 6'h11, 32'hCAFE_0011);
        push(1, 32'd0, 1'b0);
        wait_done(1, 20, cyc, nwr, nrd, a0, d0);
        chk("rw_write_cycles", 64'(nwr), 64'd2);
        chk("rw_no_read", 64'(nrd), 64'd0);
        repeat (2) @(negedge clk);

`ifdef MAILBOX_ARB_TIMEOUT_EN
        // Timeout with a mailbox that never answers.
        mdl_stall = 1'b1;
        issue(0, 0, 1, 6'h3F, 32'h0);
        push(0, 32'd0, 1'b1);
        wait_done(0, 40, cyc, nwr, nrd, a0, d0);
        chk("to_latency", 64'(cyc), 64'd17);
        chk("to_strobe_cycles", 64'(nrd), 64'd16);
        chk("to_done_strobes", {62'd0, bus.mbx_write, bus.mbx_read}, 64'd0);
        mdl_stall = 1'b0;
        repeat (2) @(negedge clk);
        issue(0, 1, 0, 6'h04, 32'h0000_0044);
        push(0, 32'd0, 1'b0);
        wait_done(0, 20, cyc, nwr, nrd, a0, d0);
        chk("to_recover_latency", 64'(cyc), 64'd3);
        repeat (2) @(negedge clk);
`endif

        // Reset during WAIT aborts without a completion.
        issue(0, 1, 0, 6'h05, 32'h0000_0055);
        @(negedge clk);
        chk("rstw_strobe_up", 64'(bus.mbx_write), 64'd1);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("rstw_strobes", {62'd0, bus.mbx_write, bus.mbx_read}, 64'd0);
        chk("rstw_ready", 64'(bus.req_ready), 64'd0);
        bus.req_write = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        seen_rdy = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (bus.req_ready != '0) seen_rdy++;
        end
        chk("rstw_no_ready", 64'(seen_rdy), 64'd0);
        issue(3, 1, 0, 6'h06, 32'h0000_0063);
        issue(0, 1, 0, 6'h07, 32'h0000_0070);
        push(0, 32'd0, 1'b0);
        push(3, 32'd0, 1'b0);
        wait_done(0, 20, cyc, nwr, nrd, a0, d0);
        chk("rstw_first_latency", 64'(cyc), 64'd3);
        wait_done(3, 20, cyc, nwr, nrd, a0, d0);
        chk("rstw_second_latency", 64'(cyc), 64'd4);
        repeat (3) @(negedge clk);

        chk("sb_empty", 64'(sb_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1);
    end

endmodule
